grid_move_engine: RTL and testbench

- Sequential game-logic core that owns and updates the 64-bit 2048 board consumed by the renderer. It is the writer side of the grid interface.
- Accepts move commands (left/right/up/down) and new-game commands. Slides and merges one line per cycle, then spawns a new tile into an empty cell.
- Exports the board plus done/changed/win/game_over status to the top-level controller.

---
 rtl/grid_move_engine.sv | 311 +++++++++++++++++++++++++++++++
 tb/tb_grid_move_engine.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/grid_move_engine.sv
`default_nettype none
// ============================================================================
// Module   : grid_move_engine
// Purpose  : 2048 game-logic core. Owns the 4x4 board (4-bit exponents),
//            executes slide/merge moves one line per cycle, spawns new tiles
//            into empty cells and reports done/changed/win/game_over.
// Ports    : clk, rst_n        - clock, asynchronous active-low reset
//            cmd_valid/ready   - command handshake (accepted only in IDLE)
//            cmd_new_game      - clear board and spawn two tiles
//            cmd_dir           - 00 left, 01 right, 10 up, 11 down
//            rnd               - random bits captured at command acceptance
//            grid              - cell i=row*4+col at grid[4*i+:4]
//            done/changed      - completion pulse and board-altered flag
//            win/game_over     - sticky win, no-moves-left status
// Revision : 1.0 - initial release
// ============================================================================
module grid_move_engine #(
    parameter int WIN_EXP = 11
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_new_game,
    input  logic [1:0]  cmd_dir,
    input  logic [15:0] rnd,
    output logic [63:0] grid,
    output logic        done,
    output logic        changed,
    output logic        win,
    output logic        game_over
);

    localparam logic [4:0] c_WIN_EXP = 5'(WIN_EXP);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_MOVE  = 3'd2,
        S_SPAWN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Registers and their next-state values
    // ------------------------------------------------------------------
    state_t      r_state,       w_state_nxt;
    logic [63:0] r_grid,        w_grid_nxt;
    logic [9:0]  r_rnd_q,       w_rnd_q_nxt;
    logic [1:0]  r_dir,         w_dir_nxt;
    logic [1:0]  r_line,        w_line_nxt;
    logic        r_changed_acc, w_changed_acc_nxt;
    logic [1:0]  r_spawn_cnt,   w_spawn_cnt_nxt;
    logic [3:0]  r_scan,        w_scan_nxt;
    logic [3:0]  r_scan_cnt,    w_scan_cnt_nxt;
    logic        r_done,        w_done_nxt;
    logic        r_changed,     w_changed_nxt;
    logic        r_win,         w_win_nxt;
    logic        r_game_over,   w_game_over_nxt;

    // Only rnd[9:0] carry meaning; the upper bits are intentionally dropped.
    logic w_unused_rnd;
    assign w_unused_rnd = ^rnd[15:10];

    // Cell index of position pos (0 = destination end) within the line.
    function automatic logic [3:0] cell_idx(input logic [1:0] dir,
                                            input logic [1:0] line,
                                            input logic [1:0] pos);
        case (dir)
            2'b00:   cell_idx = {line, pos};    // left : row=line, col 0..3
            2'b01:   cell_idx = {line, ~pos};   // right: row=line, col 3..0
            2'b10:   cell_idx = {pos, line};    // up   : col=line, row 0..3
            default: cell_idx = {~pos, line};   // down : col=line, row 3..0
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Line transform: compact, merge pairs once, pad with zeros
    // ------------------------------------------------------------------
    logic [3:0]  w_idx      [4];
    logic [3:0]  w_line_in  [4];
    logic [3:0]  w_line_out [4];
    logic [3:0]  w_cmp      [8];   // oversized so cmp[i+1] is always in range
    logic [2:0]  w_cmp_cnt;
    logic [1:0]  w_out_cnt;
    logic        w_skip;
    logic        w_merge_win;
    logic        w_line_changed;
    logic [63:0] w_grid_moved;

    always_comb begin
        w_grid_moved   = r_grid;
        w_merge_win    = 1'b0;
        w_line_changed = 1'b0;
        w_cmp_cnt      = 3'd0;
        w_out_cnt      = 2'd0;
        w_skip         = 1'b0;
        for (int i = 0; i < 8; i++) begin
            w_cmp[i] = 4'd0;
        end
        for (int p = 0; p < 4; p++) begin
            w_idx[p]      = cell_idx(r_dir, r_line, 2'(p));
            w_line_in[p]  = r_grid[{w_idx[p], 2'b00} +: 4];
            w_line_out[p] = 4'd0;
        end
        for (int p = 0; p < 4; p++) begin
            if (w_line_in[p] != 4'd0) begin
                w_cmp[w_cmp_cnt] = w_line_in[p];
                w_cmp_cnt        = w_cmp_cnt + 3'd1;
            end
        end
        // A merged cell consumes its partner (skip), so each tile merges once.
        // Exponent 15 is never merged to keep the 4-bit cell from wrapping.
        for (int i = 0; i < 4; i++) begin
            if (w_skip) begin
                w_skip = 1'b0;
            end else if (w_cmp[i] != 4'd0) begin
                if ((w_cmp[i] == w_cmp[i+1]) && (w_cmp[i] != 4'hF)) begin
                    w_line_out[w_out_cnt] = w_cmp[i] + 4'd1;
                    if ({1'b0, w_cmp[i] + 4'd1} >= c_WIN_EXP) begin
                        w_merge_win = 1'b1;
                    end
                    w_skip = 1'b1;
                end else begin
                    w_line_out[w_out_cnt] = w_cmp[i];
                end
                w_out_cnt = w_out_cnt + 2'd1;
            end
        end
        for (int p = 0; p < 4; p++) begin
            w_grid_moved[{w_idx[p], 2'b00} +: 4] = w_line_out[p];
            if (w_line_out[p] != w_line_in[p]) begin
                w_line_changed = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Board status: over when full and no equal orthogonal neighbours
    // ------------------------------------------------------------------
    logic w_game_over;

    always_comb begin
        w_game_over = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (r_grid[4*i +: 4] == 4'd0) w_game_over = 1'b0;
        end
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (r_grid[16*r + 4*c +: 4] == r_grid[16*r + 4*c + 4 +: 4]) w_game_over = 1'b0;
            end
        end
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (r_grid[16*r + 4*c +: 4] == r_grid[16*r + 4*c + 16 +: 4]) w_game_over = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Spawn helpers: the extra tile of a new game (spawn_cnt==2) uses
    // rnd bit 9, every other spawned tile uses bit 8.
    // ------------------------------------------------------------------
    logic [3:0] w_scan_cell;
    logic [3:0] w_spawn_val;
    logic       w_spawn_bit;

    assign w_scan_cell = r_grid[{r_scan, 2'b00} +: 4];
    assign w_spawn_bit = (r_spawn_cnt == 2'd2) ? r_rnd_q[9] : r_rnd_q[8];
    assign w_spawn_val = w_spawn_bit ? 4'd2 : 4'd1;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt       = r_state;
        w_grid_nxt        = r_grid;
        w_rnd_q_nxt       = r_rnd_q;
        w_dir_nxt         = r_dir;
        w_line_nxt        = r_line;
        w_changed_acc_nxt = r_changed_acc;
        w_spawn_cnt_nxt   = r_spawn_cnt;
        w_scan_nxt        = r_scan;
        w_scan_cnt_nxt    = r_scan_cnt;
        w_done_nxt        = 1'b0;
        w_changed_nxt     = r_changed;
        w_win_nxt         = r_win;
        w_game_over_nxt   = r_game_over;

        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_rnd_q_nxt = rnd[9:0];
                    if (cmd_new_game) begin
                        w_state_nxt       = S_CLEAR;
                        w_changed_acc_nxt = 1'b1;
                        w_win_nxt         = 1'b0;
                        w_game_over_nxt   = 1'b0;
                    end else begin
                        w_state_nxt       = S_MOVE;
                        w_dir_nxt         = cmd_dir;
                        w_line_nxt        = 2'd0;
                        w_changed_acc_nxt = 1'b0;
                    end
                end
            end

            S_CLEAR: begin
                w_grid_nxt      = 64'd0;
                w_spawn_cnt_nxt = 2'd2;
                w_scan_nxt      = r_rnd_q[3:0];
                w_scan_cnt_nxt  = 4'd0;
                w_state_nxt     = S_SPAWN;
            end

            S_MOVE: begin
                w_grid_nxt = w_grid_moved;
                w_line_nxt = r_line + 2'd1;
                if (w_line_changed) w_changed_acc_nxt = 1'b1;
                if (w_merge_win)    w_win_nxt         = 1'b1;
                if (r_line == 2'd3) begin
                    if (r_changed_acc || w_line_changed) begin
                        w_spawn_cnt_nxt = 2'd1;
                        w_scan_nxt      = r_rnd_q[3:0];
                        w_scan_cnt_nxt  = 4'd0;
                        w_state_nxt     = S_SPAWN;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end
            end

            S_SPAWN: begin
                if (w_scan_cell == 4'd0) begin
                    w_grid_nxt[{r_scan, 2'b00} +: 4] = w_spawn_val;
                    w_spawn_cnt_nxt = r_spawn_cnt - 2'd1;
                    w_scan_cnt_nxt  = 4'd0;
                    if (r_spawn_cnt == 2'd1) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        // Second tile restarts at a fresh random cell; if it
                        // is the one just filled, the scan simply moves on.
                        w_scan_nxt = r_rnd_q[7:4];
                    end
                end else begin
                    w_scan_nxt = r_scan + 4'd1;
                    if (r_scan_cnt == 4'd15) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_scan_cnt_nxt = r_scan_cnt + 4'd1;
                    end
                end
            end

            S_DONE: begin
                w_done_nxt      = 1'b1;
                w_changed_nxt   = r_changed_acc;
                w_game_over_nxt = w_game_over;
                w_state_nxt     = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_grid        <= 64'd0;
            r_rnd_q       <= 10'd0;
            r_dir         <= 2'd0;
            r_line        <= 2'd0;
            r_changed_acc <= 1'b0;
            r_spawn_cnt   <= 2'd0;
            r_scan        <= 4'd0;
            r_scan_cnt    <= 4'd0;
            r_done        <= 1'b0;
            r_changed     <= 1'b0;
            r_win         <= 1'b0;
            r_game_over   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_grid        <= w_grid_nxt;
            r_rnd_q       <= w_rnd_q_nxt;
            r_dir         <= w_dir_nxt;
            r_line        <= w_line_nxt;
            r_changed_acc <= w_changed_acc_nxt;
            r_spawn_cnt   <= w_spawn_cnt_nxt;
            r_scan        <= w_scan_nxt;
            r_scan_cnt    <= w_scan_cnt_nxt;
            r_done        <= w_done_nxt;
            r_changed     <= w_changed_nxt;
            r_win         <= w_win_nxt;
            r_game_over   <= w_game_over_nxt;
        end
    end

    assign cmd_ready = (r_state == S_IDLE);
    assign grid      = r_grid;
    assign done      = r_done;
    assign changed   = r_changed;
    assign win       = r_win;
    assign game_over = r_game_over;

endmodule
`default_nettype wire

// File: tb/tb_grid_move_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_grid_move_engine
// Purpose  : Self-checking bench for grid_move_engine. A hand-derived vector
//            table walks a fixed game from reset, a mid-move reset is
//            exercised, then random play is compared to a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_grid_move_engine;

    localparam int TB_WIN = 4;   // low win exponent so random play reaches it

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_new_game = 1'b0;
    logic [1:0]  cmd_dir = 2'd0;
    logic [15:0] rnd = 16'd0;
    logic        cmd_ready;
    logic [63:0] grid;
    logic        done;
    logic        changed;
    logic        win;
    logic        game_over;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    grid_move_engine #(.WIN_EXP(TB_WIN)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_new_game (cmd_new_game),
        .cmd_dir      (cmd_dir),
        .rnd          (rnd),
        .grid         (grid),
        .done         (done),
        .changed      (changed),
        .win          (win),
        .game_over    (game_over)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: board as 16 integers
    // ------------------------------------------------------------------
    int mb[16];
    bit m_win;
    bit m_go;

    function automatic int cell_of(input int dir, input int line, input int pos);
        case (dir)
            0:       return line * 4 + pos;
            1:       return line * 4 + 3 - pos;
            2:       return pos * 4 + line;
            default: return (3 - pos) * 4 + line;
        endcase
    endfunction

    task automatic model_move(input int dir, output bit chg);
        int idx[4];
        int q[$];
        int res[$];
        int v;
        chg = 1'b0;
        for (int line = 0; line < 4; line++) begin
            q.delete();
            res.delete();
            for (int p = 0; p < 4; p++) begin
                idx[p] = cell_of(dir, line, p);
                if (mb[idx[p]] != 0) q.push_back(mb[idx[p]]);
            end
            while (q.size() > 0) begin
                v = q.pop_front();
                if (q.size() > 0 && q[0] == v && v != 15) begin
                    void'(q.pop_front());
                    res.push_back(v + 1);
                    if (v + 1 >= TB_WIN) m_win = 1'b1;
                end else begin
                    res.push_back(v);
                end
            end
            while (res.size() < 4) res.push_back(0);
            for (int p = 0; p < 4; p++) begin
                if (mb[idx[p]] != res[p]) chg = 1'b1;
                mb[idx[p]] = res[p];
            end
        end
    endtask

    task automatic model_spawn(input int count, input logic [15:0] r, output int k);
        int pos;
        int miss;
        int left;
        pos  = int'(r[3:0]);
        miss = 0;
        left = count;
        k    = 0;
        while (left > 0 && miss < 16) begin
            k++;
            if (mb[pos] == 0) begin
                mb[pos] = (((left == 2) ? r[9] : r[8]) == 1'b1) ? 2 : 1;
                left--;
                miss = 0;
                if (left > 0) pos = int'(r[7:4]);
            end else begin
                pos = (pos + 1) % 16;
                miss++;
            end
        end
    endtask

    function automatic bit model_over();
        for (int i = 0; i < 16; i++) if (mb[i] == 0) return 1'b0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (mb[r*4+c] == mb[r*4+c+1]) return 1'b0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 4; c++)
                if (mb[r*4+c] == mb[r*4+c+4]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [63:0] model_pack();
        logic [63:0] g;
        g = 64'd0;
        for (int i = 0; i < 16; i++) g[4*i +: 4] = 4'(mb[i]);
        return g;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mb[i] = 0;
        m_win = 1'b0;
        m_go  = 1'b0;
    endtask

    // Expected changed flag and latency (edges from acceptance to done).
    task automatic model_cmd(input bit ng, input int dir, input logic [15:0] r,
                             output bit chg, output int lat);
        int k;
        if (ng) begin
            model_reset();
            model_spawn(2, r, k);
            chg = 1'b1;
            lat = 2 + k;
        end else begin
            model_move(dir, chg);
            if (chg) begin
                model_spawn(1, r, k);
                lat = 5 + k;
            end else begin
                lat = 5;
            end
        end
        m_go = model_over();
    endtask

    // ------------------------------------------------------------------
    // Command driver. Optionally drives ignored junk commands while busy,
    // only up to the edge on which the engine should be in DONE.
    // ------------------------------------------------------------------
    task automatic run_cmd(input bit ng, input logic [1:0] dir, input logic [15:0] r,
                           input bit junk, input int exp_lat, output int lat);
        int wc;
        wc = 0;
        while (!cmd_ready && wc < 40) begin
            @(posedge clk); #1;
            wc++;
        end
        check("ready_before_cmd", {63'd0, cmd_ready}, 64'd1);
        cmd_valid    = 1'b1;
        cmd_new_game = ng;
        cmd_dir      = dir;
        rnd          = r;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        rnd       = 16'($urandom);
        lat       = -1;
        for (int c = 1; c <= 40; c++) begin
            if (junk && c < exp_lat) begin
                cmd_valid    = 1'b1;
                cmd_new_game = 1'($urandom_range(0, 1));
                cmd_dir      = 2'($urandom_range(0, 3));
            end else begin
                cmd_valid = 1'b0;
            end
            @(posedge clk); #1;
            if (done) begin
                lat = c;
                break;
            end
        end
        cmd_valid    = 1'b0;
        cmd_new_game = 1'b0;
        @(posedge clk); #1;
        check("done_pulse_width", {63'd0, done}, 64'd0);
    endtask

    // ------------------------------------------------------------------
    // Hand-derived vector table (from reset, WIN_EXP=4)
    // ------------------------------------------------------------------
    typedef struct {
        bit          ng;
        logic [1:0]  dir;
        logic [15:0] rnd;
        logic [63:0] grid;
        bit          chg;
        int          lat;
        bit          win;
    } vec_t;

    vec_t vecs[10];

    task automatic reset_mid_move();
        cmd_valid    = 1'b1;
        cmd_new_game = 1'b0;
        cmd_dir      = 2'd0;
        rnd          = 16'd0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("midrst_grid",    grid, 64'd0);
        check("midrst_done",    {63'd0, done}, 64'd0);
        check("midrst_changed", {63'd0, changed}, 64'd0);
        check("midrst_win",     {63'd0, win}, 64'd0);
        check("midrst_gover",   {63'd0, game_over}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("midrst_ready", {63'd0, cmd_ready}, 64'd1);
        check("midrst_grid2", grid, 64'd0);
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int  lat;
        int  exp_lat;
        bit  exp_chg;
        bit  ng;
        logic [1:0] dir;
        logic [15:0] r;

        vecs[0] = '{1'b1, 2'd0, 16'h0250, 64'h0000_0000_0010_0002, 1'b1, 4, 1'b0};
        vecs[1] = '{1'b0, 2'd0, 16'h0000, 64'h0000_0000_0001_0012, 1'b1, 7, 1'b0};
        vecs[2] = '{1'b0, 2'd0, 16'h0000, 64'h0000_0000_0001_0012, 1'b0, 5, 1'b0};
        vecs[3] = '{1'b0, 2'd3, 16'h0100, 64'h0011_0002_0000_0002, 1'b1, 6, 1'b0};
        vecs[4] = '{1'b0, 2'd1, 16'h0003, 64'h2000_2000_0001_2000, 1'b1, 7, 1'b0};
        vecs[5] = '{1'b0, 2'd2, 16'h0000, 64'h0000_0000_2000_3011, 1'b1, 7, 1'b0};
        vecs[6] = '{1'b0, 2'd0, 16'h0000, 64'h0000_0000_0002_0132, 1'b1, 8, 1'b0};
        vecs[7] = '{1'b0, 2'd3, 16'h0000, 64'h0133_0000_0000_0001, 1'b1, 6, 1'b0};
        vecs[8] = '{1'b0, 2'd0, 16'h0000, 64'h0014_0000_0000_0011, 1'b1, 7, 1'b1};
        vecs[9] = '{1'b1, 2'd0, 16'h0250, 64'h0000_0000_0010_0002, 1'b1, 4, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_grid",    grid, 64'd0);
        check("rst_done",    {63'd0, done}, 64'd0);
        check("rst_changed", {63'd0, changed}, 64'd0);
        check("rst_win",     {63'd0, win}, 64'd0);
        check("rst_gover",   {63'd0, game_over}, 64'd0);
        check("rst_ready",   {63'd0, cmd_ready}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed table; the mid-move reset precedes the final new game
        for (int i = 0; i < 10; i++) begin
            if (i == 9) reset_mid_move();
            run_cmd(vecs[i].ng, vecs[i].dir, vecs[i].rnd, (i % 2) == 1, vecs[i].lat, lat);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
            check($sformatf("vec%0d_grid", i), grid, vecs[i].grid);
            check($sformatf("vec%0d_changed", i), {63'd0, changed}, {63'd0, vecs[i].chg});
            check($sformatf("vec%0d_win", i), {63'd0, win}, {63'd0, vecs[i].win});
            check($sformatf("vec%0d_gover", i), {63'd0, game_over}, 64'd0);
        end

        // Random play against the model, starting from a fresh reset
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
        for (int i = 0; i < 800; i++) begin
            ng  = (i == 0) || m_go || ($urandom_range(0, 249) == 0);
            dir = 2'($urandom_range(0, 3));
            r   = 16'($urandom);
            model_cmd(ng, int'(dir), r, exp_chg, exp_lat);
            run_cmd(ng, dir, r, 1'($urandom_range(0, 1)), exp_lat, lat);
            check($sformatf("rnd%0d_latency", i), 64'(lat), 64'(exp_lat));
            check($sformatf("rnd%0d_grid", i), grid, model_pack());
            check($sformatf("rnd%0d_changed", i), {63'd0, changed}, {63'd0, exp_chg});
            check($sformatf("rnd%0d_win", i), {63'd0, win}, {63'd0, m_win});
            check($sformatf("rnd%0d_gover", i), {63'd0, game_over}, {63'd0, m_go});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
